// File: rtl/qcl_sync_stable_capture.sv
// Commits a synchronized multi-bit bus only after stable_cycles_p identical samples; valid/yumi output handshake.
// Latency: value first sampled at edge e0 appears on data_o/v_o after edge e0+stable_cycles_p-1.
// Backpressure: none upstream; an unconsumed value is overwritten by the next commit and overrun_o latches.
// Optional: define QCL_SYNC_STABLE_GRAY_CHECK_EN to flag multi-bit input changes on gray_err_o.
module qcl_sync_stable_capture #(
  parameter int                 width_p         = 8,
  parameter int                 stable_cycles_p = 3,
  parameter logic [width_p-1:0] reset_val_p     = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  output logic               overrun_o,
  output logic               gray_err_o
);

  if (stable_cycles_p < 2) begin : g_bad_stable_cycles
    $error("qcl_sync_stable_capture: stable_cycles_p must be >= 2");
  end

  localparam int                cnt_w      = $clog2(stable_cycles_p + 1);
  localparam logic [cnt_w-1:0]  cnt_sat    = cnt_w'(stable_cycles_p);
  localparam logic [cnt_w-1:0]  cnt_commit = cnt_w'(stable_cycles_p - 1);
  localparam logic [cnt_w-1:0]  cnt_one    = cnt_w'(1);

  logic [width_p-1:0] cand_r;
  logic [cnt_w-1:0]   cnt_r;
  logic               same;
  logic               commit;

  assign same = (data_i == cand_r);
  // Returning to the already-committed value must not re-present it downstream.
  assign commit = same && (cnt_r == cnt_commit) && (cand_r != data_o);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cand_r    <= reset_val_p;
      cnt_r     <= cnt_sat;
      data_o    <= reset_val_p;
      v_o       <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (!same) begin
        cand_r <= data_i;
        cnt_r  <= cnt_one;
      end else if (cnt_r < cnt_sat) begin
        cnt_r <= cnt_r + cnt_one;
      end

      if (commit) begin
        data_o <= cand_r;
        v_o    <= 1'b1;
        if (v_o && !yumi_i) begin
          overrun_o <= 1'b1;
        end
      end else if (v_o && yumi_i) begin
        v_o <= 1'b0;
      end
    end
  end

`ifdef QCL_SYNC_STABLE_GRAY_CHECK_EN
  logic [width_p-1:0] diff;
  logic               multi_bit;
  logic               gray_err_r;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign diff      = data_i ^ cand_r;
  assign multi_bit = ((diff & (diff - 1'b1)) != '0);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      gray_err_r <= 1'b0;
    end else if (multi_bit) begin
      gray_err_r <= 1'b1;
    end
  end

  assign gray_err_o = gray_err_r;
`else
  assign gray_err_o = 1'b0;
`endif

endmodule
